instruction_fetch: RTL and testbench

Sequential fetch stage for the single-issue MIPS core. Holds the program counter, reads 32-bit words from instruction memory over a req/ack handshake, and presents each word with its 6-bit opcode to the control unit and decode logic over a valid/ready handshake. It also consumes the decoded branch controls (beq/bne, zero flag, immediate) and register-jump requests to select the next PC.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/instruction_fetch_if.sv | 36 +++
 rtl/next_pc_sel.sv | 36 +++
 rtl/instruction_fetch.sv | 101 ++++++++++
 tb/tb_instruction_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode constants, fetch state encoding and default reset vector shared by the MIPS core
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ANDI   = 6'h0c;
    localparam logic [5:0] ORI    = 6'h0d;
    localparam logic [5:0] LUI    = 6'h0f;
    localparam logic [5:0] LW     = 6'h23;
    localparam logic [5:0] SW     = 6'h2b;
    localparam logic [5:0] BEQ    = 6'h04;
    localparam logic [5:0] BNE    = 6'h05;

    typedef enum logic [1:0] {
        RESET_HOLD,
        FETCH,
        HOLD,
        ERROR
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem req/ack bus, decode valid/ready handshake and redirect controls of the fetch stage
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  imem_req_o;
    logic [ADDR_WIDTH-1:0] imem_addr_o;
    logic                  imem_ack_i;
    logic [31:0]           imem_rdata_i;
    logic [31:0]           instr_o;
    logic [5:0]            opcode_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic [ADDR_WIDTH-1:0] pc_plus4_o;
    logic                  instr_valid_o;
    logic                  instr_ready_i;
    logic                  branch_eq_i;
    logic                  branch_ne_i;
    logic                  zero_i;
    logic [15:0]           branch_imm_i;
    logic                  jump_reg_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  fetch_err_o;

    modport master (
        output imem_req_o, imem_addr_o, instr_o, opcode_o, pc_o, pc_plus4_o,
               instr_valid_o, fetch_err_o,
        input  imem_ack_i, imem_rdata_i, instr_ready_i, branch_eq_i, branch_ne_i,
               zero_i, branch_imm_i, jump_reg_i, jump_addr_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, instr_o, opcode_o, pc_o, pc_plus4_o,
               instr_valid_o, fetch_err_o,
        output imem_ack_i, imem_rdata_i, instr_ready_i, branch_eq_i, branch_ne_i,
               zero_i, branch_imm_i, jump_reg_i, jump_addr_i
    );
endinterface

// File: rtl/next_pc_sel.sv
// next_pc_sel: picks jr target, taken branch target or pc+4; ALIGN_CHECK_EN flags misaligned jr targets
module next_pc_sel #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc_plus4_i,
    input  logic                  branch_eq_i,
    input  logic                  branch_ne_i,
    input  logic                  zero_i,
    input  logic [15:0]           branch_imm_i,
    input  logic                  jump_reg_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic [ADDR_WIDTH-1:0] next_pc_o,
    output logic                  misalign_o
);
    logic                  taken;
    logic [ADDR_WIDTH-1:0] branch_target;

    assign taken         = (branch_eq_i & zero_i) | (branch_ne_i & ~zero_i);
    assign branch_target = pc_plus4_i + {{(ADDR_WIDTH-18){branch_imm_i[15]}}, branch_imm_i, 2'b00};

    // jr wins over branch; its low bits are cleared so an untrapped misaligned target realigns
    always_comb begin
        next_pc_o = jump_reg_i ? {jump_addr_i[ADDR_WIDTH-1:2], 2'b00}
                  : taken      ? branch_target
                  :              pc_plus4_i;
    end

    // only jr can misalign: the PC and branch offsets are always word multiples
`ifdef ALIGN_CHECK_EN
    assign misalign_o = jump_reg_i & (|jump_addr_i[1:0]);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^jump_addr_i[1:0];
    assign misalign_o      = 1'b0;
`endif
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, imem req/ack fetch and valid/ready hand-off to decode (optional ALIGN_CHECK_EN trap)
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input logic               clk_i,
    input logic               rst_n_i,
    instruction_fetch_if.master bus
);
    fetch_state_e          state_q, state_d;
    logic                  req_q, req_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  misalign;
    logic                  accept;

    assign pc_plus4 = pc_q + ADDR_WIDTH'(4);
    assign accept   = valid_q & bus.instr_ready_i;

    next_pc_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_next_pc_sel (
        .pc_plus4_i   (pc_plus4),
        .branch_eq_i  (bus.branch_eq_i),
        .branch_ne_i  (bus.branch_ne_i),
        .zero_i       (bus.zero_i),
        .branch_imm_i (bus.branch_imm_i),
        .jump_reg_i   (bus.jump_reg_i),
        .jump_addr_i  (bus.jump_addr_i),
        .next_pc_o    (next_pc),
        .misalign_o   (misalign)
    );

    // state and registered outputs; reset abandons any outstanding request
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= RESET_HOLD;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= '0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    // fetch sequencing: request until ack, hold until accept, then redirect or trap
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        err_d   = err_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        case (state_q)
            RESET_HOLD: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                if (bus.imem_ack_i) begin
                    state_d = HOLD;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    instr_d = bus.imem_rdata_i;
                end
            end
            HOLD: begin
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = misalign ? ERROR : FETCH;
                    err_d   = misalign;
                    req_d   = ~misalign;
                    pc_d    = misalign ? pc_q : next_pc;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
        endcase
    end

    assign bus.imem_req_o    = req_q;
    assign bus.imem_addr_o   = pc_q;
    assign bus.instr_o       = instr_q;
    assign bus.opcode_o      = instr_q[31:26];
    assign bus.pc_o          = pc_q;
    assign bus.pc_plus4_o    = pc_plus4;
    assign bus.instr_valid_o = valid_q;
    assign bus.fetch_err_o   = err_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus, memory responder and transaction-level model of the fetch stage
module tb_instruction_fetch;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   mem_wait = 0;
    logic force_ack = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_if #(.ADDR_WIDTH(32)) bus ();

    instruction_fetch #(.ADDR_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == RST_PC) ? 32'h2008_0005 : {LW, 10'h022, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    endtask

    // memory: answers after mem_wait extra cycles, or unconditionally when force_ack is set
    initial begin
        int cnt;
        cnt = 0;
        bus.imem_ack_i   = 1'b0;
        bus.imem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            if (force_ack || (bus.imem_req_o && cnt >= mem_wait)) begin
                bus.imem_ack_i   = 1'b1;
                bus.imem_rdata_i = mem_word(bus.imem_addr_o);
                cnt = 0;
            end else begin
                bus.imem_ack_i   = 1'b0;
                bus.imem_rdata_i = 32'hDEAD_BEEF;
                cnt = bus.imem_req_o ? cnt + 1 : 0;
            end
        end
    end

    // model: transaction rules applied on each rising edge, outputs compared 1ns later
    initial begin
        logic        m_req, m_valid, m_err;
        logic [31:0] m_pc, m_instr, tgt;
        int          off;
        m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_pc = RST_PC; m_instr = 32'h0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_req = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_pc = RST_PC; m_instr = 32'h0;
            end else if (m_err) begin
                m_req = 1'b0;
            end else if (m_valid) begin
                if (bus.instr_ready_i) begin
                    if (bus.jump_reg_i) tgt = bus.jump_addr_i;
                    else if ((bus.branch_eq_i && bus.zero_i) || (bus.branch_ne_i && !bus.zero_i)) begin
                        off = $signed(bus.branch_imm_i);
                        tgt = m_pc + 32'd4 + 32'(off * 4);
                    end else tgt = m_pc + 32'd4;
                    m_valid = 1'b0;
`ifdef ALIGN_CHECK_EN
                    if (tgt % 4 != 0) m_err = 1'b1;
                    else begin m_pc = tgt; m_req = 1'b1; end
`else
                    m_pc = tgt & ~32'd3;
                    m_req = 1'b1;
`endif
                end
            end else if (m_req) begin
                if (bus.imem_ack_i) begin
                    m_instr = bus.imem_rdata_i; m_req = 1'b0; m_valid = 1'b1;
                end
            end else m_req = 1'b1;
            #1;
            chk("m_req", bus.imem_req_o, m_req);
            chk("m_valid", bus.instr_valid_o, m_valid);
            chk("m_err", bus.fetch_err_o, m_err);
            if (m_req) chk("m_addr", bus.imem_addr_o, m_pc);
            if (m_valid) begin
                chk("m_instr", bus.instr_o, m_instr);
                chk("m_pc", bus.pc_o, m_pc);
                chk("m_opcode", 32'(bus.opcode_o), 32'(m_instr[31:26]));
                chk("m_pc_plus4", bus.pc_plus4_o, m_pc + 32'd4);
            end
        end
    end

    // one accept with the given redirect controls, returning at the negedge after the accept edge
    task automatic accept(input logic jr, input logic [31:0] ja, input logic beq, input logic bne,
                          input logic z, input logic [15:0] imm);
        int n;
        n = 0;
        while (!bus.instr_valid_o && n < 50) begin @(negedge clk); n++; end
        chk("accept_valid", bus.instr_valid_o, 1);
        bus.jump_reg_i = jr; bus.jump_addr_i = ja; bus.branch_eq_i = beq;
        bus.branch_ne_i = bne; bus.zero_i = z; bus.branch_imm_i = imm;
        bus.instr_ready_i = 1'b1;
        @(negedge clk);
        bus.instr_ready_i = 1'b0;
        bus.jump_reg_i = 1'b0; bus.branch_eq_i = 1'b0; bus.branch_ne_i = 1'b0;
        bus.zero_i = 1'b0; bus.branch_imm_i = 16'h0; bus.jump_addr_i = 32'h0;
    endtask

    initial begin
        int n;
        bus.instr_ready_i = 1'b0; bus.branch_eq_i = 1'b0; bus.branch_ne_i = 1'b0;
        bus.zero_i = 1'b0; bus.branch_imm_i = 16'h0; bus.jump_reg_i = 1'b0; bus.jump_addr_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_req", bus.imem_req_o, 0);
        chk("rst_addr", bus.imem_addr_o, RST_PC);
        chk("rst_pc", bus.pc_o, RST_PC);
        chk("rst_valid", bus.instr_valid_o, 0);
        chk("rst_instr", bus.instr_o, 0);
        chk("rst_err", bus.fetch_err_o, 0);
        rst_n = 1'b1;
        bus.instr_ready_i = 1'b1;
        @(negedge clk);
        chk("first_req", bus.imem_req_o, 1);
        chk("first_addr", bus.imem_addr_o, RST_PC);
        @(negedge clk);
        chk("first_valid", bus.instr_valid_o, 1);
        chk("first_opcode", 32'(bus.opcode_o), 32'(ADDI));
        chk("first_instr", bus.instr_o, 32'h2008_0005);
        chk("first_pc_plus4", bus.pc_plus4_o, 32'h0040_0004);
        @(negedge clk);
        chk("second_req", bus.imem_req_o, 1);
        chk("second_addr", bus.imem_addr_o, 32'h0040_0004);
        bus.instr_ready_i = 1'b0;

        accept(1'b1, 32'h0040_0010, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("jr_addr", bus.imem_addr_o, 32'h0040_0010);
        accept(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 16'hFFFF);
        chk("beq_back_addr", bus.imem_addr_o, 32'h0040_0010);
        accept(1'b1, 32'h0040_0020, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("jr2_addr", bus.imem_addr_o, 32'h0040_0020);
        accept(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 16'h0003);
        chk("bne_nt_addr", bus.imem_addr_o, 32'h0040_0024);

        n = 0;
        while (!bus.instr_valid_o && n < 50) begin @(negedge clk); n++; end
        repeat (5) begin
            @(negedge clk);
            chk("hold_req", bus.imem_req_o, 0);
            chk("hold_pc", bus.pc_o, 32'h0040_0024);
            chk("hold_instr", bus.instr_o, mem_word(32'h0040_0024));
        end
        mem_wait = 2;
        accept(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("seq_addr", bus.imem_addr_o, 32'h0040_0028);
        accept(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("wait_seq_addr", bus.imem_addr_o, 32'h0040_002C);
        mem_wait = 0;
        accept(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 16'h0002);
        chk("both_br_addr", bus.imem_addr_o, 32'h0040_0038);

        accept(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("top_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        accept(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("wrap_addr", bus.imem_addr_o, 32'h0);

        mem_wait = 10;
        accept(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("pend_req", bus.imem_req_o, 1);
        @(negedge clk);
        rst_n = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", bus.imem_req_o, 0);
        chk("rst_mid_pc", bus.pc_o, RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        force_ack = 1'b0;
        mem_wait = 0;
        @(negedge clk);
        chk("restart_req", bus.imem_req_o, 1);
        chk("restart_addr", bus.imem_addr_o, RST_PC);
        n = 0;
        while (!bus.instr_valid_o && n < 50) begin @(negedge clk); n++; end
        chk("restart_instr", bus.instr_o, 32'h2008_0005);

        accept(1'b1, 32'h0040_0102, 1'b0, 1'b0, 1'b0, 16'h0);
`ifdef ALIGN_CHECK_EN
        chk("misalign_err", bus.fetch_err_o, 1);
        chk("misalign_req", bus.imem_req_o, 0);
        repeat (3) @(negedge clk);
        chk("err_stuck", bus.fetch_err_o, 1);
        chk("err_no_req", bus.imem_req_o, 0);
        chk("err_no_valid", bus.instr_valid_o, 0);
`else
        chk("realign_addr", bus.imem_addr_o, 32'h0040_0100);
        chk("realign_err", bus.fetch_err_o, 0);
        repeat (3) @(negedge clk);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not reach summary, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
